alu_share_arbiter: RTL and testbench

//  Shares one combinational RISCV ALU between two requesters, e.g. the core

---
 rtl/alu_share_arbiter_if.sv | 36 +++
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response channel pair for one ALU sharing port
// Purpose: bundles one requester's request channel (operands and opcode) and
//   its response channel (result, flags, error) behind valid/ready handshakes.
// Ports (signals):
//   req_valid/req_ready   request handshake
//   req_a, req_b          operands A and B
//   req_op                {Ainv, Binv, ALUsel[2:0]}
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            captured ALU result (0 on error)
//   rsp_flags             {Zero, Negative, Carryout, Overflow}
//   rsp_err               opcode was not a legal encoding
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [4:0]       req_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       rsp_flags;
   logic             rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Purpose: arbitrates two requesters onto a single external ALU. The granted
//   request's operands are registered, drive the ALU for one EXEC cycle, and
//   the result/flags are captured and held on the owner's response channel
//   until consumed. Illegal opcodes bypass the ALU and return err=1.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   port0, port1    request/response channels (slave side)
//   alu_srca/srcb   registered operands to the ALU
//   alu_ainv/binv   registered invert controls to the ALU
//   alu_sel         registered function select to the ALU
//   alu_result      ALU result
//   alu_zero, alu_negative, alu_carryout, alu_overflow   ALU flags
module alu_share_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_arbiter_if.slave port0,
   alu_share_arbiter_if.slave port1,
   output logic [WIDTH-1:0]  alu_srca,
   output logic [WIDTH-1:0]  alu_srcb,
   output logic              alu_ainv,
   output logic              alu_binv,
   output logic [2:0]        alu_sel,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_carryout,
   input  logic              alu_overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             last_grant;
   logic             owner;
   logic             err_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;

   logic             grant0;
   logic             grant1;
   logic             accept;
   logic [WIDTH-1:0] acc_a;
   logic [WIDTH-1:0] acc_b;
   logic [4:0]       acc_op;

   function automatic logic op_legal(input logic [4:0] op);
      case (op)
         5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7,
         5'd10, 5'd11, 5'd12, 5'd24: op_legal = 1'b1;
         default:                    op_legal = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant decode: a lone valid port wins; on a tie the port that did not
   // win last time wins (last_grant resets to 1 so port 0 takes the first tie).
   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state)
         IDLE: begin
            grant0 = port0.req_valid && (!port1.req_valid ||  last_grant);
            grant1 = port1.req_valid && (!port0.req_valid || !last_grant);
            if (grant0 || grant1) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (owner ? port1.rsp_ready : port0.rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign accept = grant0 || grant1;
   assign acc_a  = grant1 ? port1.req_a  : port0.req_a;
   assign acc_b  = grant1 ? port1.req_b  : port0.req_b;
   assign acc_op = grant1 ? port1.req_op : port0.req_op;

   // The alu_* outputs are the operand registers themselves, so the ALU only
   // sees a change when a legal op is accepted and holds still otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
         alu_srca   <= '0;
         alu_srcb   <= '0;
         alu_ainv   <= 1'b0;
         alu_binv   <= 1'b0;
         alu_sel    <= 3'd0;
      end else begin
         if (accept) begin
            owner      <= grant1;
            last_grant <= grant1;
            if (op_legal(acc_op)) begin
               err_q    <= 1'b0;
               alu_srca <= acc_a;
               alu_srcb <= acc_b;
               alu_ainv <= acc_op[4];
               alu_binv <= acc_op[3];
               alu_sel  <= acc_op[2:0];
            end else begin
               err_q    <= 1'b1;
               result_q <= '0;
               flags_q  <= '0;
            end
         end
         if (state == EXEC && !err_q) begin
            result_q <= alu_result;
            flags_q  <= {alu_zero, alu_negative, alu_carryout, alu_overflow};
         end
      end
   end

   assign port0.req_ready  = grant0;
   assign port1.req_ready  = grant1;

   assign port0.rsp_valid  = (state == RESP) && !owner;
   assign port1.rsp_valid  = (state == RESP) &&  owner;

   // Response payload is only presented to the port that owns the operation.
   assign port0.rsp_result = owner ? '0     : result_q;
   assign port0.rsp_flags  = owner ? 4'd0   : flags_q;
   assign port0.rsp_err    = owner ? 1'b0   : err_q;
   assign port1.rsp_result = owner ? result_q : '0;
   assign port1.rsp_flags  = owner ? flags_q  : 4'd0;
   assign port1.rsp_err    = owner ? err_q    : 1'b0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_srca, alu_srcb, alu_result;
   logic        alu_ainv, alu_binv;
   logic [2:0]  alu_sel;
   logic        alu_zero, alu_negative, alu_carryout, alu_overflow;

   int vectors     = 0;
   int miscompares = 0;

   alu_share_arbiter_if #(.WIDTH(32)) p0 ();
   alu_share_arbiter_if #(.WIDTH(32)) p1 ();

   alu_share_arbiter #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .port0        (p0.slave),
      .port1        (p1.slave),
      .alu_srca     (alu_srca),
      .alu_srcb     (alu_srcb),
      .alu_ainv     (alu_ainv),
      .alu_binv     (alu_binv),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_negative (alu_negative),
      .alu_carryout (alu_carryout),
      .alu_overflow (alu_overflow)
   );

   always #5 clk = ~clk;

   // Reference RISC-V style ALU: 0 and, 1 or, 2 add, 3 sltu, 4 slt, 5 xor, 6 sll, 7 srl
   logic [31:0] ma, mb;
   logic [32:0] msum;
   always_comb begin
      ma   = alu_ainv ? ~alu_srca : alu_srca;
      mb   = alu_binv ? ~alu_srcb : alu_srcb;
      msum = {1'b0, ma} + {1'b0, mb} + {32'd0, alu_binv};
      alu_overflow = (ma[31] == mb[31]) && (msum[31] != ma[31]);
      alu_carryout = msum[32];
      case (alu_sel)
         3'd0: alu_result = ma & mb;
         3'd1: alu_result = ma | mb;
         3'd2: alu_result = msum[31:0];
         3'd3: alu_result = {31'd0, ~msum[32]};
         3'd4: alu_result = {31'd0, msum[31] ^ alu_overflow};
         3'd5: alu_result = ma ^ mb;
         3'd6: alu_result = ma << mb[4:0];
         default: alu_result = ma >> mb[4:0];
      endcase
      alu_zero     = (alu_result == 32'd0);
      alu_negative = alu_result[31];
   end

   task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op);
      if (p == 0) begin
         p0.req_valid = v; p0.req_a = a; p0.req_b = b; p0.req_op = op;
      end else begin
         p1.req_valid = v; p1.req_a = a; p1.req_b = b; p1.req_op = op;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      drive(1, 1'b0, 32'd0, 32'd0, 5'd0);
      p0.rsp_ready = 1'b1;
      p1.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if (p0.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req0_ready got %b exp 0", p0.req_ready); end
      vectors++; if (p1.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req1_ready got %b exp 0", p1.req_ready); end
      vectors++; if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 00", {p0.rsp_valid, p1.rsp_valid}); end
      vectors++; if ({alu_srca, alu_srcb} !== 64'd0) begin miscompares++; $display("FAIL reset_alu_src got %h exp 0", {alu_srca, alu_srcb}); end
      vectors++; if ({alu_ainv, alu_binv, alu_sel} !== 5'd0) begin miscompares++; $display("FAIL reset_alu_ctl got %h exp 0", {alu_ainv, alu_binv, alu_sel}); end
      vectors++; if ({p0.rsp_result, p0.rsp_flags, p0.rsp_err} !== 37'd0) begin miscompares++; $display("FAIL reset_rsp0_fields got %h exp 0", {p0.rsp_result, p0.rsp_flags, p0.rsp_err}); end
   endtask

   task automatic test_single_add;
      drive(0, 1'b1, 32'd5, 32'd7, 5'd2);
      #1;
      vectors++; if ({p0.req_ready, p1.req_ready} !== 2'b10) begin miscompares++; $display("FAIL add_ready got %b exp 10", {p0.req_ready, p1.req_ready}); end
      @(negedge clk);                       // EXEC
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      #1;
      vectors++; if (p0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_exec_valid got %b exp 0", p0.rsp_valid); end
      vectors++; if ({alu_srca, alu_srcb} !== {32'd5, 32'd7}) begin miscompares++; $display("FAIL add_alu_src got %h exp 0000000500000007", {alu_srca, alu_srcb}); end
      vectors++; if ({alu_ainv, alu_binv, alu_sel} !== 5'd2) begin miscompares++; $display("FAIL add_alu_ctl got %h exp 02", {alu_ainv, alu_binv, alu_sel}); end
      @(negedge clk);                       // RESP
      vectors++; if (p0.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_rsp_valid got %b exp 1", p0.rsp_valid); end
      vectors++; if (p0.rsp_result !== 32'd12) begin miscompares++; $display("FAIL add_result got %0d exp 12", p0.rsp_result); end
      vectors++; if ({p0.rsp_flags, p0.rsp_err} !== 5'b0000_0) begin miscompares++; $display("FAIL add_flags_err got %b exp 00000", {p0.rsp_flags, p0.rsp_err}); end
      vectors++; if (p1.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_rsp1_valid got %b exp 0", p1.rsp_valid); end
      @(negedge clk);                       // IDLE
      vectors++; if (p0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_rsp_drop got %b exp 0", p0.rsp_valid); end
   endtask

   task automatic test_round_robin;
      logic [4:0] winners;
      winners = 5'b01010;                   // bit i = expected winner of op i
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1'b1, 32'd3, 32'd3, 5'd10);
      drive(1, 1'b1, 32'd3, 32'd3, 5'd10);
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++; if ({p1.req_ready, p0.req_ready} !== (winners[i] ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_grant%0d got %b exp %b", i, {p1.req_ready, p0.req_ready}, winners[i] ? 2'b10 : 2'b01); end
         @(negedge clk);
         @(negedge clk);
         vectors++; if ({p1.rsp_valid, p0.rsp_valid} !== (winners[i] ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_rsp_valid%0d got %b exp %b", i, {p1.rsp_valid, p0.rsp_valid}, winners[i] ? 2'b10 : 2'b01); end
         vectors++; if ((winners[i] ? {p1.rsp_result, p1.rsp_flags} : {p0.rsp_result, p0.rsp_flags}) !== {32'd0, 4'b1010}) begin miscompares++; $display("FAIL rr_result%0d got %h exp 0000000_a", i, winners[i] ? {p1.rsp_result, p1.rsp_flags} : {p0.rsp_result, p0.rsp_flags}); end
         @(negedge clk);
      end
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      drive(1, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic test_illegal;
      drive(1, 1'b1, 32'd9, 32'd9, 5'd3);
      #1;
      vectors++; if (p1.req_ready !== 1'b1) begin miscompares++; $display("FAIL ill_ready got %b exp 1", p1.req_ready); end
      @(negedge clk);                       // EXEC
      drive(1, 1'b0, 32'd0, 32'd0, 5'd0);
      #1;
      vectors++; if ({alu_srca, alu_srcb} !== {32'd3, 32'd3}) begin miscompares++; $display("FAIL ill_alu_src got %h exp 0000000300000003", {alu_srca, alu_srcb}); end
      vectors++; if ({alu_ainv, alu_binv, alu_sel} !== 5'd10) begin miscompares++; $display("FAIL ill_alu_ctl got %h exp 0a", {alu_ainv, alu_binv, alu_sel}); end
      vectors++; if (p1.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ill_exec_valid got %b exp 0", p1.rsp_valid); end
      @(negedge clk);                       // RESP
      vectors++; if ({p1.rsp_valid, p1.rsp_err} !== 2'b11) begin miscompares++; $display("FAIL ill_valid_err got %b exp 11", {p1.rsp_valid, p1.rsp_err}); end
      vectors++; if ({p1.rsp_result, p1.rsp_flags} !== 36'd0) begin miscompares++; $display("FAIL ill_result_flags got %h exp 0", {p1.rsp_result, p1.rsp_flags}); end
      vectors++; if (p0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ill_rsp0_valid got %b exp 0", p0.rsp_valid); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      p0.rsp_ready = 1'b0;
      drive(0, 1'b1, 32'd1, 32'd2, 5'd2);
      @(negedge clk);                       // EXEC
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      drive(1, 1'b1, 32'd10, 32'd20, 5'd2);
      @(negedge clk);                       // RESP
      for (int k = 0; k < 5; k++) begin
         #1;
         vectors++; if ({p0.rsp_valid, p0.rsp_result, p0.rsp_flags, p0.rsp_err} !== {1'b1, 32'd3, 4'd0, 1'b0}) begin miscompares++; $display("FAIL bp_hold%0d got %h exp 1_00000003_0_0", k, {p0.rsp_valid, p0.rsp_result, p0.rsp_flags, p0.rsp_err}); end
         vectors++; if ({p0.req_ready, p1.req_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_req_ready%0d got %b exp 00", k, {p0.req_ready, p1.req_ready}); end
         @(negedge clk);
      end
      p0.rsp_ready = 1'b1;
      #1;
      vectors++; if (p0.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_ready_cycle_valid got %b exp 1", p0.rsp_valid); end
      @(negedge clk);                       // IDLE
      vectors++; if ({p0.rsp_valid, p1.req_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_release got %b exp 01", {p0.rsp_valid, p1.req_ready}); end
      @(negedge clk);                       // EXEC for port 1
      drive(1, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge clk);                       // RESP
      vectors++; if ({p1.rsp_valid, p1.rsp_result} !== {1'b1, 32'd30}) begin miscompares++; $display("FAIL bp_port1_result got %h exp 1_0000001e", {p1.rsp_valid, p1.rsp_result}); end
      @(negedge clk);
   endtask

   task automatic test_reset_exec;
      drive(0, 1'b1, 32'd4, 32'd4, 5'd2);
      @(negedge clk);                       // EXEC
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      rst = 1'b1;
      #1;
      vectors++; if ({p0.rsp_valid, p1.rsp_valid, p0.req_ready, p1.req_ready} !== 4'b0000) begin miscompares++; $display("FAIL rex_handshakes got %b exp 0000", {p0.rsp_valid, p1.rsp_valid, p0.req_ready, p1.req_ready}); end
      vectors++; if ({alu_srca, alu_srcb, alu_ainv, alu_binv, alu_sel} !== 69'd0) begin miscompares++; $display("FAIL rex_alu_outputs got %h exp 0", {alu_srca, alu_srcb, alu_ainv, alu_binv, alu_sel}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if ({p0.rsp_valid, p0.rsp_result} !== 33'd0) begin miscompares++; $display("FAIL rex_no_rsp got %h exp 0", {p0.rsp_valid, p0.rsp_result}); end
      drive(0, 1'b1, 32'd1, 32'd1, 5'd2);
      drive(1, 1'b1, 32'd2, 32'd2, 5'd2);
      #1;
      vectors++; if ({p0.req_ready, p1.req_ready} !== 2'b10) begin miscompares++; $display("FAIL rex_first_grant got %b exp 10", {p0.req_ready, p1.req_ready}); end
      @(negedge clk);
      @(negedge clk);                       // RESP port 0
      vectors++; if ({p0.rsp_valid, p0.rsp_result} !== {1'b1, 32'd2}) begin miscompares++; $display("FAIL rex_port0_result got %h exp 1_00000002", {p0.rsp_valid, p0.rsp_result}); end
      @(negedge clk);                       // IDLE, tie goes to port 1
      #1;
      vectors++; if ({p0.req_ready, p1.req_ready} !== 2'b01) begin miscompares++; $display("FAIL rex_second_grant got %b exp 01", {p0.req_ready, p1.req_ready}); end
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      drive(1, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge clk);                       // RESP port 1
      vectors++; if ({p1.rsp_valid, p1.rsp_result} !== {1'b1, 32'd4}) begin miscompares++; $display("FAIL rex_port1_result got %h exp 1_00000004", {p1.rsp_valid, p1.rsp_result}); end
      @(negedge clk);
   endtask

   task automatic test_compare_ops;
      drive(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd12);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge clk);
      vectors++; if ({p0.rsp_valid, p0.rsp_result, p0.rsp_err} !== {1'b1, 32'd1, 1'b0}) begin miscompares++; $display("FAIL slt_op12 got %h exp 1_00000001_0", {p0.rsp_valid, p0.rsp_result, p0.rsp_err}); end
      @(negedge clk);
      drive(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd11);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge clk);
      vectors++; if ({p0.rsp_valid, p0.rsp_result, p0.rsp_err} !== {1'b1, 32'd0, 1'b0}) begin miscompares++; $display("FAIL sltu_op11 got %h exp 1_00000000_0", {p0.rsp_valid, p0.rsp_result, p0.rsp_err}); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_illegal();
      test_backpressure();
      test_reset_exec();
      test_compare_ops();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
